// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// The struct gives the soc a single bundled view of one manager's request.
package mem_arbiter_pkg;

  localparam int MEM_NUM_MGR    = 2;
  localparam int MGR_IBUS       = 0;
  localparam int MGR_DBUS       = 1;
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_STRB_WIDTH = MEM_DATA_WIDTH / 8;

  typedef logic [$clog2(MEM_NUM_MGR)-1:0] mgr_id_t;

  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
    logic [MEM_STRB_WIDTH-1:0] wstrb;
  } mem_req_t;

  // Wrap with an explicit compare so non-power-of-two manager counts work.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
// Grant is combinational; the pointer advances only on cycles with a grant.
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_id_o,
  output logic                 gnt_valid_o
);

  localparam int IdW = $clog2(N);

  logic [IdW-1:0] last_ptr_reg;
  logic [IdW-1:0] last_ptr_next;
  logic [IdW-1:0] win_id;
  logic           win_valid;

  // Scan last_ptr+1, last_ptr+2, ... and keep the first requester found.
  always_comb begin
    int idx;
    win_id    = '0;
    win_valid = 1'b0;
    idx       = rr_next(int'(last_ptr_reg), N);
    for (int k = 0; k < N; k++) begin
      if (!win_valid && req_i[idx]) begin
        win_valid = 1'b1;
        win_id    = IdW'(idx);
      end
      idx = rr_next(idx, N);
    end
  end

  // No grant may leak out while reset is held low.
  assign gnt_valid_o = win_valid && rst_ni;
  assign gnt_id_o    = win_id;

  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign gnt_o[gi] = gnt_valid_o && (win_id == IdW'(gi));
  end

  always_comb begin
    last_ptr_next = last_ptr_reg;
    if (gnt_valid_o) begin
      last_ptr_next = win_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_ptr_reg <= IdW'(N - 1);
    end else begin
      last_ptr_reg <= last_ptr_next;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported, 1-cycle-latency sram among NumMgr managers.
// Muxes the granted request onto the sram and routes the response to its owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int NumMgr     = MEM_NUM_MGR,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumMgr-1:0]            m_req_i,
  input  logic [NumMgr-1:0]            m_we_i,
  input  logic [NumMgr*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NumMgr*DATA_WIDTH-1:0] m_wdata_i,
  input  logic [NumMgr*STRB_WIDTH-1:0] m_wstrb_i,
  output logic [NumMgr-1:0]            m_gnt_o,
  output logic [NumMgr-1:0]            m_rvalid_o,
  output logic [DATA_WIDTH-1:0]        m_rdata_o,
  output logic                         wvalid_o,
  output logic [ADDR_WIDTH-1:0]        awaddr_o,
  output logic [DATA_WIDTH-1:0]        wdata_o,
  output logic [STRB_WIDTH-1:0]        wstrb_o,
  output logic [ADDR_WIDTH-1:0]        araddr_o,
  input  logic [DATA_WIDTH-1:0]        rdata_i
);

  localparam int IdW = $clog2(NumMgr);

  logic                  we_arr    [NumMgr];
  logic [ADDR_WIDTH-1:0] addr_arr  [NumMgr];
  logic [DATA_WIDTH-1:0] wdata_arr [NumMgr];
  logic [STRB_WIDTH-1:0] wstrb_arr [NumMgr];

  logic [IdW-1:0] gnt_id;
  logic           gnt_valid;

  logic           rsp_valid_reg;
  logic           rsp_valid_next;
  logic [IdW-1:0] rsp_id_reg;
  logic [IdW-1:0] rsp_id_next;

  for (genvar gi = 0; gi < NumMgr; gi++) begin : g_unpack
    assign we_arr[gi]    = m_we_i[gi];
    assign addr_arr[gi]  = m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = m_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb_arr[gi] = m_wstrb_i[gi*STRB_WIDTH +: STRB_WIDTH];
  end

  rr_arbiter #(
    .N(NumMgr)
  ) u_rr_arbiter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (m_req_i),
    .gnt_o      (m_gnt_o),
    .gnt_id_o   (gnt_id),
    .gnt_valid_o(gnt_valid)
  );

  // Idle cycles drive zeros so the sram sees a quiet bus.
  always_comb begin
    wvalid_o = 1'b0;
    awaddr_o = '0;
    araddr_o = '0;
    wdata_o  = '0;
    wstrb_o  = '0;
    if (gnt_valid) begin
      wvalid_o = we_arr[gnt_id];
      awaddr_o = addr_arr[gnt_id];
      araddr_o = addr_arr[gnt_id];
      wdata_o  = wdata_arr[gnt_id];
      wstrb_o  = wstrb_arr[gnt_id];
    end
  end

  always_comb begin
    rsp_valid_next = gnt_valid;
    rsp_id_next    = rsp_id_reg;
    if (gnt_valid) begin
      rsp_id_next = gnt_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
    end
  end

  // Reads and write acks both return exactly one cycle after the grant.
  for (genvar gi = 0; gi < NumMgr; gi++) begin : g_rvalid
    assign m_rvalid_o[gi] = rst_ni && rsp_valid_reg && (rsp_id_reg == IdW'(gi));
  end

  assign m_rdata_o = rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a write-first, 1-cycle-latency sram model.
// Inputs change just after posedge; outputs are sampled on negedge.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic        wvalid;
  logic [31:0] awaddr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wstrb;
  logic [31:0] araddr;
  logic [31:0] sram_rdata;
  logic        preload;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .m_req_i   (req),
    .m_we_i    (we),
    .m_addr_i  (addr),
    .m_wdata_i (wdata),
    .m_wstrb_i (wstrb),
    .m_gnt_o   (gnt),
    .m_rvalid_o(rvalid),
    .m_rdata_o (rdata),
    .wvalid_o  (wvalid),
    .awaddr_o  (awaddr),
    .wdata_o   (sram_wdata),
    .wstrb_o   (sram_wstrb),
    .araddr_o  (araddr),
    .rdata_i   (sram_rdata)
  );

  // Word-addressed sram model: byte-strobed write, then write-first read.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (preload) begin
      mem[8'h10] = 32'hDEAD_BEEF;
      mem[8'h20] = 32'hAAAA_AAAA;
    end
    if (wvalid) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wstrb[b]) mem[awaddr[9:2]][b*8 +: 8] = sram_wdata[b*8 +: 8];
      end
    end
    sram_rdata <= mem[araddr[9:2]];
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mgr(input int m, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req[m]          = r;
    we[m]           = w;
    addr[m*32 +: 32]  = a;
    wdata[m*32 +: 32] = d;
    wstrb[m*4 +: 4]   = s;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    preload = 1'b1;
    set_mgr(MGR_IBUS, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    set_mgr(MGR_DBUS, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
      checks++; if (wvalid !== 1'b0) begin failures++; $display("FAIL reset_wvalid: got %b expected 0", wvalid); end
      checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
      next_cycle();
    end
    rst_n = 1'b1;
    preload = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL reset_first_gnt: got %b expected 01", gnt); end
    checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL reset_first_rvalid: got %b expected 00", rvalid); end
    next_cycle();
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalid !== 2'b01) begin failures++; $display("FAIL reset_release_rvalid: got %b expected 01", rvalid); end
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_idle_gnt: got %b expected 00", gnt); end
    next_cycle();
    $display("test_reset done");
  endtask

  task automatic test_single_reader;
    set_mgr(MGR_IBUS, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) req = 2'b00;
      @(negedge clk);
      checks++;
      if (gnt !== ((i < 4) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL single_gnt[%0d]: got %b", i, gnt); end
      if (i < 4) begin
        checks++; if (araddr !== 32'h40) begin failures++; $display("FAIL single_araddr[%0d]: got %h expected 00000040", i, araddr); end
        checks++; if (wvalid !== 1'b0) begin failures++; $display("FAIL single_wvalid[%0d]: got %b expected 0", i, wvalid); end
      end
      if (i > 0) begin
        checks++; if (rvalid !== 2'b01) begin failures++; $display("FAIL single_rvalid[%0d]: got %b expected 01", i, rvalid); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata[%0d]: got %h expected deadbeef", i, rdata); end
      end
      $display("single_reader cycle %0d gnt=%b rvalid=%b rdata=%h", i, gnt, rvalid, rdata);
      next_cycle();
    end
    @(negedge clk);
    checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL single_drain_rvalid: got %b expected 00", rvalid); end
    next_cycle();
  endtask

  task automatic test_write_read;
    set_mgr(MGR_DBUS, 1'b1, 1'b1, 32'h80, 32'h1234_5678, 4'b0011);
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL wr_gnt: got %b expected 10", gnt); end
    checks++; if (wvalid !== 1'b1) begin failures++; $display("FAIL wr_wvalid: got %b expected 1", wvalid); end
    checks++; if (awaddr !== 32'h80) begin failures++; $display("FAIL wr_awaddr: got %h expected 00000080", awaddr); end
    checks++; if (sram_wdata !== 32'h1234_5678) begin failures++; $display("FAIL wr_wdata: got %h expected 12345678", sram_wdata); end
    checks++; if (sram_wstrb !== 4'b0011) begin failures++; $display("FAIL wr_wstrb: got %b expected 0011", sram_wstrb); end
    $display("write cycle gnt=%b wvalid=%b awaddr=%h", gnt, wvalid, awaddr);
    next_cycle();
    set_mgr(MGR_DBUS, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL rd_gnt: got %b expected 10", gnt); end
    checks++; if (wvalid !== 1'b0) begin failures++; $display("FAIL rd_wvalid: got %b expected 0", wvalid); end
    checks++; if (rvalid !== 2'b10) begin failures++; $display("FAIL wr_ack: got %b expected 10", rvalid); end
    next_cycle();
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalid !== 2'b10) begin failures++; $display("FAIL rd_rvalid: got %b expected 10", rvalid); end
    checks++; if (rdata !== 32'hAAAA_5678) begin failures++; $display("FAIL rd_rdata: got %h expected aaaa5678", rdata); end
    checks++; if (araddr !== 32'h0) begin failures++; $display("FAIL idle_araddr: got %h expected 00000000", araddr); end
    $display("read back rvalid=%b rdata=%h", rvalid, rdata);
    next_cycle();
  endtask

  task automatic test_contention;
    logic [1:0] exp_gnt;
    logic [1:0] prev_gnt;
    prev_gnt = 2'b00;
    set_mgr(MGR_IBUS, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    set_mgr(MGR_DBUS, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++; if (gnt !== exp_gnt) begin failures++; $display("FAIL cont_gnt[%0d]: got %b expected %b", i, gnt, exp_gnt); end
      checks++; if (araddr !== ((exp_gnt == 2'b01) ? 32'h40 : 32'h80)) begin failures++; $display("FAIL cont_araddr[%0d]: got %h", i, araddr); end
      checks++; if (rvalid !== prev_gnt) begin failures++; $display("FAIL cont_rvalid[%0d]: got %b expected %b", i, rvalid, prev_gnt); end
      if (prev_gnt != 2'b00) begin
        checks++;
        if (rdata !== ((prev_gnt == 2'b01) ? 32'hDEAD_BEEF : 32'hAAAA_5678)) begin
          failures++; $display("FAIL cont_rdata[%0d]: got %h", i, rdata);
        end
      end
      $display("contention cycle %0d gnt=%b rvalid=%b rdata=%h", i, gnt, rvalid, rdata);
      prev_gnt = exp_gnt;
      next_cycle();
    end
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalid !== 2'b10) begin failures++; $display("FAIL cont_tail_rvalid: got %b expected 10", rvalid); end
    checks++; if (rdata !== 32'hAAAA_5678) begin failures++; $display("FAIL cont_tail_rdata: got %h expected aaaa5678", rdata); end
    next_cycle();
  endtask

  task automatic test_withdrawn;
    set_mgr(MGR_IBUS, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    set_mgr(MGR_DBUS, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL wd_gnt: got %b expected 01", gnt); end
    next_cycle();
    req = 2'b00;
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL wd_gnt_after: got %b expected 00", gnt); end
    checks++; if (rvalid !== 2'b01) begin failures++; $display("FAIL wd_rvalid: got %b expected 01", rvalid); end
    next_cycle();
    req = 2'b11;
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL wd_ptr: got %b expected 10", gnt); end
    checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL wd_no_rvalid: got %b expected 00", rvalid); end
    $display("withdrawn: follow-up gnt=%b rvalid=%b", gnt, rvalid);
    next_cycle();
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalid !== 2'b10) begin failures++; $display("FAIL wd_tail_rvalid: got %b expected 10", rvalid); end
    next_cycle();
  endtask

  task automatic test_reset_midflight;
    set_mgr(MGR_IBUS, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
    set_mgr(MGR_DBUS, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL mid_gnt: got %b expected 10", gnt); end
    next_cycle();
    rst_n = 1'b0;
    req = 2'b01;
    @(negedge clk);
    checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL mid_rvalid_in_reset: got %b expected 00", rvalid); end
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL mid_gnt_in_reset: got %b expected 00", gnt); end
    next_cycle();
    rst_n = 1'b1;
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL mid_rvalid_after: got %b expected 00", rvalid); end
    next_cycle();
    req = 2'b11;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL mid_restart_gnt: got %b expected 01", gnt); end
    next_cycle();
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalid !== 2'b01) begin failures++; $display("FAIL mid_restart_rvalid: got %b expected 01", rvalid); end
    $display("reset_midflight restart rvalid=%b", rvalid);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    req   = 2'b00;
    we    = 2'b00;
    addr  = '0;
    wdata = '0;
    wstrb = '0;
    test_reset();
    test_single_reader();
    test_write_read();
    test_contention();
    test_withdrawn();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
